alu_zero: RTL and testbench

ALU_ZERO -- requirements
Module: alu_zero

---
 rtl/alu_zero.sv | 77 +++++++
 tb/tb_alu_zero.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_zero.sv
// Zero detect on operand A: combinational is_zero plus a 1-cycle registered copy is_zero_q.
// No flow control; the registered flag updates on every rising clk edge.
module alu_zero #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A,
  output logic                  is_zero,
  output logic                  is_zero_q
);

  localparam int LEAF_NODES = (DATA_WIDTH + 3) / 4;

  function automatic int nodes_at(input int lvl);
    int n;
    n = LEAF_NODES;
    for (int i = 0; i < lvl; i++) n = (n + 3) / 4;
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = LEAF_NODES;
    l = 1;
    while (n > 1) begin
      n = (n + 3) / 4;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  logic is_zero_d;

  // Level 0 is 4-input NORs over A; every level above reduces 4:1 with ANDs.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int N = nodes_at(lv);
    logic [N-1:0]   node;
    logic [4*N-1:0] in_pad;

    if (lv == 0) begin : g_leaf
      // Spare NOR inputs tied low so they never mask a set bit.
      always_comb begin
        in_pad                 = '0;
        in_pad[DATA_WIDTH-1:0] = A;
      end
      for (genvar j = 0; j < N; j++) begin : g_nor
        assign node[j] = ~|in_pad[4*j +: 4];
      end
    end else begin : g_and
      localparam int NP = nodes_at(lv - 1);
      // Spare AND inputs tied high so they never force a false "non-zero".
      always_comb begin
        in_pad         = '1;
        in_pad[NP-1:0] = g_lvl[lv-1].node;
      end
      for (genvar j = 0; j < N; j++) begin : g_and4
        assign node[j] = &in_pad[4*j +: 4];
      end
    end
  end

  assign is_zero   = g_lvl[LEVELS-1].node[0];
  assign is_zero_d = is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_zero_q <= 1'b0;
    end else begin
      is_zero_q <= is_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_zero.sv
module tb_alu_zero;

  logic        clk;
  logic        rst_n;
  logic [63:0] a64;
  logic [0:0]  a1;
  logic [4:0]  a5;
  logic        z64, z64_q, z1, z1_q, z5, z5_q;
  int          checks;
  int          errors;

  alu_zero #(.DATA_WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .A(a64), .is_zero(z64), .is_zero_q(z64_q));
  alu_zero #(.DATA_WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .A(a1),  .is_zero(z1),  .is_zero_q(z1_q));
  alu_zero #(.DATA_WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .A(a5),  .is_zero(z5),  .is_zero_q(z5_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the flag is simply "the operand equals zero".
  function automatic logic ref_zero(input logic [63:0] v);
    return (v == 64'd0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a64 = 64'd0; a1 = 1'b0; a5 = 5'd0;
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL reset_q got %b want 0", z64_q); end
    checks++;
    if (z64 !== 1'b1) begin errors++; $display("FAIL reset_comb got %b want 1", z64); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL reset_hold_q got %b want 0", z64_q); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL release_q got %b want 0", z64_q); end
    @(posedge clk);
    #1;
    checks++;
    if (z64_q !== 1'b1) begin errors++; $display("FAIL first_edge_q got %b want 1", z64_q); end
  endtask

  task automatic test_all_zero();
    a64 = 64'hFFFF_0000_0000_0001;
    #50;
    a64 = 64'd0;
    #5000;
    checks++;
    if (z64 !== 1'b1) begin errors++; $display("FAIL all_zero got %b want 1", z64); end
  endtask

  task automatic test_walk_fill();
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 64; i++) begin
      v[i] = 1'b1;
      a64 = v;
      #2;
      checks++;
      if (z64 !== ref_zero(v)) begin errors++; $display("FAIL walk_fill bit %0d got %b want %b", i, z64, ref_zero(v)); end
    end
  endtask

  task automatic test_walk_clear();
    logic [63:0] v;
    v = '1;
    for (int i = 63; i >= 0; i--) begin
      v[i] = 1'b0;
      a64 = v;
      #2;
      checks++;
      if (z64 !== ref_zero(v)) begin errors++; $display("FAIL walk_clear bit %0d got %b want %b", i, z64, ref_zero(v)); end
    end
  endtask

  task automatic test_narrow();
    logic [63:0] pats5 [4];
    pats5[0] = 64'd0; pats5[1] = 64'd1; pats5[2] = 64'd16; pats5[3] = 64'd31;
    for (int i = 0; i < 4; i++) begin
      a5 = pats5[i][4:0];
      #2;
      checks++;
      if (z5 !== ref_zero(pats5[i])) begin errors++; $display("FAIL narrow5 A=%0d got %b want %b", pats5[i], z5, ref_zero(pats5[i])); end
    end
    for (int i = 0; i < 2; i++) begin
      a1 = i[0];
      #2;
      checks++;
      if (z1 !== (i == 0)) begin errors++; $display("FAIL narrow1 A=%0d got %b want %b", i, z1, (i == 0)); end
    end
    a64 = 64'h8000_0000_0000_0000;
    #2;
    checks++;
    if (z64 !== 1'b0) begin errors++; $display("FAIL msb_only got %b want 0", z64); end
    a64 = 64'd1;
    #2;
    checks++;
    if (z64 !== 1'b0) begin errors++; $display("FAIL lsb_only got %b want 0", z64); end
  endtask

  task automatic test_random();
    logic [63:0] v;
    logic [63:0] v5;
    logic [63:0] v1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      case ($urandom_range(7))
        0:       v = 64'd0;
        1:       v = 64'd1 << $urandom_range(63);
        default: v = {$urandom(), $urandom()};
      endcase
      v5 = ($urandom_range(3) == 0) ? 64'd0 : 64'($urandom_range(31));
      v1 = 64'($urandom_range(1));
      a64 = v; a5 = v5[4:0]; a1 = v1[0:0];
      #1;
      checks++;
      if (z64 !== ref_zero(v)) begin errors++; $display("FAIL rand64 A=%h got %b want %b", v, z64, ref_zero(v)); end
      checks++;
      if (z5 !== ref_zero(v5)) begin errors++; $display("FAIL rand5 A=%0d got %b want %b", v5, z5, ref_zero(v5)); end
      checks++;
      if (z1 !== ref_zero(v1)) begin errors++; $display("FAIL rand1 A=%0d got %b want %b", v1, z1, ref_zero(v1)); end
      @(posedge clk);
      #1;
      checks++;
      if (z64_q !== ref_zero(v)) begin errors++; $display("FAIL rand64_q A=%h got %b want %b", v, z64_q, ref_zero(v)); end
      checks++;
      if (z5_q !== ref_zero(v5)) begin errors++; $display("FAIL rand5_q A=%0d got %b want %b", v5, z5_q, ref_zero(v5)); end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a64 = 64'd0;
    @(posedge clk);
    #1;
    checks++;
    if (z64_q !== 1'b1) begin errors++; $display("FAIL reg_zero got %b want 1", z64_q); end
    @(negedge clk);
    a64 = 64'h10;
    #1;
    checks++;
    if (z64_q !== 1'b1) begin errors++; $display("FAIL reg_hold got %b want 1", z64_q); end
    @(posedge clk);
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL reg_nonzero got %b want 0", z64_q); end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    a64 = 64'd0;
    @(posedge clk);
    @(negedge clk);
    a64 = 64'h5;
    #1;
    a64 = 64'd0;
    #1;
    checks++;
    if (z64_q !== 1'b1) begin errors++; $display("FAIL glitch_hold got %b want 1", z64_q); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a64 = 64'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL mid_rst_q got %b want 0", z64_q); end
    checks++;
    if (z64 !== 1'b1) begin errors++; $display("FAIL mid_rst_comb got %b want 1", z64); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (z64_q !== 1'b0) begin errors++; $display("FAIL mid_release_q got %b want 0", z64_q); end
    @(posedge clk);
    #1;
    checks++;
    if (z64_q !== 1'b1) begin errors++; $display("FAIL mid_recover_q got %b want 1", z64_q); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_all_zero();
    test_walk_fill();
    test_walk_clear();
    test_narrow();
    test_registered();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
